// File: rtl/seq_edge_param_capture_pkg.sv
// -----------------------------------------------------------------------------
// seq_edge_param_capture_pkg
//   Shared edge-mode definitions for the edge capture block.
//   - mode encodings as seen on the 2-bit mode port
//   - edge_mode_e: the three edge kinds the detector understands
//   - decode_mode(): maps the raw port value to edge_mode_e (11 -> rising)
// -----------------------------------------------------------------------------
package seq_edge_param_capture_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10
  } edge_mode_e;

  // The unused encoding 11 falls back to rising-edge detection.
  function automatic edge_mode_e decode_mode(input logic [1:0] mode_raw);
    case (mode_raw)
      MODE_FALL: return EDGE_FALL;
      MODE_BOTH: return EDGE_BOTH;
      default:   return EDGE_RISE;
    endcase
  endfunction

endpackage

// File: rtl/seq_edge_detect.sv
// -----------------------------------------------------------------------------
// seq_edge_detect
//   Holds the previous-sample register and produces per-bit edge flags
//   selected by mode in the same cycle.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (prev -> 0)
//   i_clear  in   synchronous clear (prev -> 0)
//   i_mode   in   [1:0] edge select (00 rise, 01 fall, 10 both, 11 rise)
//   i_in     in   [p_nbits-1:0] monitored vector
//   o_edge   out  [p_nbits-1:0] combinational edge flags for this cycle
// -----------------------------------------------------------------------------
module seq_edge_detect
  import seq_edge_param_capture_pkg::*;
#(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic [1:0]         i_mode,
  input  logic [p_nbits-1:0] i_in,
  output logic [p_nbits-1:0] o_edge
);

  logic [p_nbits-1:0] r_prev;
  edge_mode_e         w_mode;

  // prev is forced to 0 by reset and clear, so the first sample afterwards
  // is compared against all-zeros and a high input reads as a rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours; blocking here would create
  // order-dependent simulation and a mismatch with synthesis.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
    end else if (i_clear) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_in;
    end
  end

  assign w_mode = decode_mode(i_mode);

  // NOTE: o_edge gets a default before the case so every path assigns it;
  // a missing assignment in combinational logic infers a latch.
  always_comb begin
    o_edge = ~r_prev & i_in;
    case (w_mode)
      EDGE_FALL: o_edge = r_prev & ~i_in;
      EDGE_BOTH: o_edge = r_prev ^ i_in;
      default:   o_edge = ~r_prev & i_in;
    endcase
  end

endmodule

// File: rtl/seq_edge_param_capture.sv
// -----------------------------------------------------------------------------
// seq_edge_param_capture
//   Sticky per-bit edge capture with read-and-clear, a saturating event
//   counter and a level interrupt.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset of all state
//   clear    in   synchronous clear of capture state (wins over rd_en)
//   mode     in   [1:0] edge select (00 rise, 01 fall, 10 both, 11 rise)
//   in_      in   [p_nbits-1:0] monitored vector
//   rd_en    in   read-and-clear request
//   out      out  [p_nbits-1:0] cap | this cycle's edges (combinational)
//   rd_val   out  registered one-cycle strobe qualifying rd_data
//   rd_data  out  [p_nbits-1:0] snapshot of out from the rd_en cycle
//   count    out  [p_cnt_nbits-1:0] saturating count of edge events
//   irq      out  registered, high while the capture register is nonzero
// -----------------------------------------------------------------------------
module seq_edge_param_capture
  import seq_edge_param_capture_pkg::*;
#(
  parameter int p_nbits     = 8,
  parameter int p_cnt_nbits = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [1:0]             mode,
  input  logic [p_nbits-1:0]     in_,
  input  logic                   rd_en,
  output logic [p_nbits-1:0]     out,
  output logic                   rd_val,
  output logic [p_nbits-1:0]     rd_data,
  output logic [p_cnt_nbits-1:0] count,
  output logic                   irq
);

  // Popcount of p_nbits bits needs clog2(p_nbits+1) bits; the sum is widened
  // by that much so the saturation compare never sees a wrapped value.
  localparam int POP_W = $clog2(p_nbits + 1);
  localparam int SUM_W = p_cnt_nbits + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {p_cnt_nbits{1'b1}}};

  logic [p_nbits-1:0]     r_cap;
  logic                   r_rd_val;
  logic [p_nbits-1:0]     r_rd_data;
  logic [p_cnt_nbits-1:0] r_count;
  logic                   r_irq;

  logic [p_nbits-1:0]     w_edge;
  logic [p_nbits-1:0]     w_out;
  logic [p_nbits-1:0]     w_cap_next;
  logic [POP_W-1:0]       w_pop;
  logic [SUM_W-1:0]       w_sum;
  logic [p_cnt_nbits-1:0] w_count_next;

  seq_edge_detect #(
    .p_nbits (p_nbits)
  ) u_edge_detect (
    .clk     (clk),
    .reset   (reset),
    .i_clear (clear),
    .i_mode  (mode),
    .i_in    (in_),
    .o_edge  (w_edge)
  );

  // Folding this cycle's edges into out is what makes a read lossless:
  // rd_data snapshots w_out, so edges arriving with rd_en are returned.
  assign w_out = r_cap | w_edge;

  // clear outranks rd_en; both empty the capture register.
  assign w_cap_next = (clear || rd_en) ? '0 : w_out;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < p_nbits; i++) begin
      w_pop = w_pop + POP_W'(w_edge[i]);
    end
  end

  assign w_sum        = {{POP_W{1'b0}}, r_count} + {{p_cnt_nbits{1'b0}}, w_pop};
  assign w_count_next = (w_sum > CNT_MAX) ? {p_cnt_nbits{1'b1}}
                                          : w_sum[p_cnt_nbits-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap     <= '0;
      r_rd_val  <= 1'b0;
      r_rd_data <= '0;
      r_count   <= '0;
      r_irq     <= 1'b0;
    end else if (clear) begin
      // rd_data deliberately keeps the last read result across a clear.
      r_cap    <= '0;
      r_rd_val <= 1'b0;
      r_count  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_cap    <= w_cap_next;
      r_rd_val <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_out;
      end
      r_count  <= w_count_next;
      r_irq    <= |w_cap_next;
    end
  end

  assign out     = w_out;
  assign rd_val  = r_rd_val;
  assign rd_data = r_rd_data;
  assign count   = r_count;
  assign irq     = r_irq;

endmodule

// File: tb/tb_seq_edge_param_capture.sv
// -----------------------------------------------------------------------------
// tb_seq_edge_param_capture
//   Directed bench for seq_edge_param_capture (p_nbits=8, p_cnt_nbits=4).
//   A behavioural model tracks the expected outputs and is compared against
//   the DUT on every falling edge; hand-computed literals pin key points.
// -----------------------------------------------------------------------------
module tb_seq_edge_param_capture;

  localparam int NB   = 8;
  localparam int CNB  = 4;
  localparam int CMAX = (1 << CNB) - 1;

  logic           clk;
  logic           reset;
  logic           clear;
  logic [1:0]     mode;
  logic [NB-1:0]  in_;
  logic           rd_en;
  logic [NB-1:0]  out;
  logic           rd_val;
  logic [NB-1:0]  rd_data;
  logic [CNB-1:0] count;
  logic           irq;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_edge_param_capture #(
    .p_nbits     (NB),
    .p_cnt_nbits (CNB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .mode    (mode),
    .in_     (in_),
    .rd_en   (rd_en),
    .out     (out),
    .rd_val  (rd_val),
    .rd_data (rd_data),
    .count   (count),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: expected state derived from the edge/capture rules.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] m_prev, m_cap, m_rd_data;
  logic          m_rd_val, m_irq;
  int            m_count;

  function automatic logic [NB-1:0] edges_of(input logic [NB-1:0] p,
                                             input logic [NB-1:0] x,
                                             input logic [1:0]    md);
    if (md == 2'b01)      return p & ~x;
    else if (md == 2'b10) return p ^ x;
    else                  return ~p & x;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [NB-1:0] e, o;
    int            c;
    if (reset) begin
      m_prev    <= '0;
      m_cap     <= '0;
      m_rd_data <= '0;
      m_rd_val  <= 1'b0;
      m_irq     <= 1'b0;
      m_count   <= 0;
    end else begin
      e = edges_of(m_prev, in_, mode);
      o = m_cap | e;
      if (clear) begin
        m_prev   <= '0;
        m_cap    <= '0;
        m_rd_val <= 1'b0;
        m_irq    <= 1'b0;
        m_count  <= 0;
      end else begin
        c = m_count + $countones(e);
        if (c > CMAX) c = CMAX;
        m_count  <= c;
        m_prev   <= in_;
        m_rd_val <= rd_en;
        if (rd_en) m_rd_data <= o;
        m_cap    <= rd_en ? '0 : o;
        m_irq    <= rd_en ? 1'b0 : (o != 0);
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("cyc_out",     64'(out),     64'(m_cap | edges_of(m_prev, in_, mode)));
    check("cyc_rd_val",  64'(rd_val),  64'(m_rd_val));
    check("cyc_rd_data", 64'(rd_data), 64'(m_rd_data));
    check("cyc_count",   64'(count),   64'(m_count));
    check("cyc_irq",     64'(irq),     64'(m_irq));
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; clear = 1'b0; mode = 2'b00; in_ = '0; rd_en = 1'b0;

    // Reset state and out during reset (prev held at 0).
    #2;
    check("rst_out",     64'(out),     64'h00);
    check("rst_rd_val",  64'(rd_val),  64'h0);
    check("rst_rd_data", 64'(rd_data), 64'h00);
    check("rst_count",   64'(count),   64'h0);
    check("rst_irq",     64'(irq),     64'h0);
    in_ = 8'h03;
    #1 check("rst_out_edge", 64'(out), 64'h03);
    cyc();
    cyc();
    in_ = 8'h00;
    reset = 1'b0;

    // Rising capture: 00 -> 05 -> 00.
    cyc();
    in_ = 8'h05;
    #1 check("rise_out_edge", 64'(out), 64'h05);
    check("rise_irq_early", 64'(irq), 64'h0);
    cyc();
    in_ = 8'h00;
    #1 check("rise_out_sticky", 64'(out), 64'h05);
    check("rise_irq", 64'(irq), 64'h1);
    check("rise_count", 64'(count), 64'h2);
    cyc();
    #1 check("rise_out_hold", 64'(out), 64'h05);

    // Falling: FF -> F0 gives 0F.
    clear = 1'b1; mode = 2'b01; in_ = 8'hFF;
    cyc();
    clear = 1'b0;
    cyc();
    in_ = 8'hF0;
    #1 check("fall_out", 64'(out), 64'h0F);
    cyc();
    #1 check("fall_count", 64'(count), 64'h4);
    check("fall_irq", 64'(irq), 64'h1);

    // Both edges after clear: 00 -> 01 -> 00.
    clear = 1'b1; mode = 2'b10; in_ = 8'h00;
    cyc();
    clear = 1'b0;
    #1 check("clr_count", 64'(count), 64'h0);
    check("clr_irq", 64'(irq), 64'h0);
    cyc();
    in_ = 8'h01;
    #1 check("both_out_rise", 64'(out), 64'h01);
    cyc();
    in_ = 8'h00;
    cyc();
    #1 check("both_count", 64'(count), 64'h2);
    check("both_out", 64'(out), 64'h01);

    // Read with a simultaneous rising edge on bit 7; mode change keeps cap.
    mode = 2'b00; in_ = 8'h80; rd_en = 1'b1;
    #1 check("rd_out_merge", 64'(out), 64'h81);
    cyc();
    rd_en = 1'b0;
    #1 check("rd_val", 64'(rd_val), 64'h1);
    check("rd_data", 64'(rd_data), 64'h81);
    check("rd_out_after", 64'(out), 64'h00);
    check("rd_irq_after", 64'(irq), 64'h0);
    check("rd_count_kept", 64'(count), 64'h3);
    cyc();
    #1 check("rd_val_drop", 64'(rd_val), 64'h0);
    check("rd_data_hold", 64'(rd_data), 64'h81);

    // Back-to-back reads with nothing captured.
    rd_en = 1'b1;
    cyc();
    #1 check("b2b_val1", 64'(rd_val), 64'h1);
    check("b2b_data1", 64'(rd_data), 64'h00);
    cyc();
    rd_en = 1'b0;
    #1 check("b2b_val2", 64'(rd_val), 64'h1);
    cyc();
    #1 check("b2b_val_end", 64'(rd_val), 64'h0);

    // Priority: clear and rd_en together with something captured.
    mode = 2'b10; in_ = 8'h00;
    cyc();
    clear = 1'b1; rd_en = 1'b1;
    cyc();
    clear = 1'b0; rd_en = 1'b0;
    #1 check("prio_rd_val", 64'(rd_val), 64'h0);
    check("prio_count", 64'(count), 64'h0);
    check("prio_out", 64'(out), 64'h00);
    check("prio_irq", 64'(irq), 64'h0);
    check("prio_rd_data", 64'(rd_data), 64'h00);

    // Saturation: 16 cycles toggling FF/00 in both-edge mode.
    for (int i = 0; i < 16; i++) begin
      in_ = (i % 2 == 0) ? 8'hFF : 8'h00;
      cyc();
      if (i == 0) check("sat_count_8", 64'(count), 64'h8);
      if (i == 1) check("sat_count_clamp", 64'(count), 64'hF);
    end
    #1 check("sat_count_hold", 64'(count), 64'hF);
    check("sat_irq", 64'(irq), 64'h1);

    // Reset asserted in the rd_en cycle.
    rd_en = 1'b1;
    #1 reset = 1'b1;
    #1 check("rstrd_val", 64'(rd_val), 64'h0);
    check("rstrd_data", 64'(rd_data), 64'h00);
    check("rstrd_count", 64'(count), 64'h0);
    check("rstrd_irq", 64'(irq), 64'h0);
    cyc();
    reset = 1'b0; rd_en = 1'b0; in_ = 8'h01;
    #1 check("rstrd_out", 64'(out), 64'h01);
    cyc();
    #1 check("rstrd_no_read", 64'(rd_val), 64'h0);
    check("rstrd_count_after", 64'(count), 64'h1);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
